// File: rtl/ahb_apb_pkg.sv
// Shared definitions for the AHB-to-APB3 bridge front end.
// Holds the controller state encoding, AHB HTRANS codes and HRESP codes.
// The optional APB3_SLVERR_EN build macro changes controller behaviour only;
// nothing in this package depends on it.
package ahb_apb_pkg;

    // Controller states. ERR1/ERR2 form the two-cycle AHB ERROR response.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DPHASE = 3'd1,
        ST_APB    = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } state_t;

    // AHB transfer types.
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // AHB-Lite response codes.
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // True for transfer types that carry data (NONSEQ or SEQ).
    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_apb_xfer_ctrl.sv
// AHB-Lite slave front end of the AHB-to-APB3 bridge.
// Captures the AHB address/data phases, stalls AHB with HREADYOUT while the
// APB transfer runs, pulses xfer_start to the sibling PENABLE scheduler and
// returns PRDATA / response to AHB.
//
// Handshake: an AHB transfer is taken when HSEL & HREADY & HTRANS is
// NONSEQ/SEQ in IDLE or ERR2. The APB transfer completes in the cycle
// where PSEL & PENABLE & PREADY are all high; until then the AHB bus is
// held with HREADYOUT low.
//
// Build option APB3_SLVERR_EN: when defined, PSLVERR at completion gives a
// two-cycle AHB ERROR response (ERR1, ERR2). When undefined PSLVERR is
// ignored and HRESP is constant OKAY.
//
// Every output is a flop or a decode of the state register, so there is no
// combinational path from AHB/APB inputs to any output.
module ahb_apb_xfer_ctrl
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETN,
    // AHB-Lite slave side
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic                  HWRITE,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    // APB3 master side
    output logic                  PSEL,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    input  logic                  PENABLE,
    input  logic                  PREADY,
    input  logic [31:0]           PRDATA,
    input  logic                  PSLVERR,
    // PENABLE scheduler
    output logic                  xfer_start
);

    state_t                state;
    logic                  hreadyout_r;
    logic                  xfer_start_r;
    logic                  psel_r;
    logic                  pwrite_r;
    logic [ADDR_WIDTH-1:0] paddr_r;
    logic [31:0]           pwdata_r;
    logic [31:0]           hrdata_r;

    logic                  accept;
    logic                  apb_done;
    logic                  slv_err;

    // Only the low ADDR_WIDTH address bits reach APB; the rest are dropped.
    logic                  unused_haddr;
    assign unused_haddr = ^HADDR;

    // A new AHB transfer is presented to this slave.
    assign accept   = HSEL & HREADY & htrans_active(HTRANS);

    // APB access phase finishes this cycle. PENABLE outside APB is harmless
    // because psel_r is only set while in ST_APB.
    assign apb_done = psel_r & PENABLE & PREADY;

`ifdef APB3_SLVERR_EN
    assign slv_err = PSLVERR;
`else
    // Slave errors are not reported to AHB in this build.
    logic unused_pslverr;
    assign unused_pslverr = PSLVERR;
    assign slv_err        = 1'b0;
`endif

    // Controller FSM together with all registered bus outputs.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state        <= ST_IDLE;
            hreadyout_r  <= 1'b1;
            xfer_start_r <= 1'b0;
            psel_r       <= 1'b0;
            pwrite_r     <= 1'b0;
            paddr_r      <= '0;
            pwdata_r     <= '0;
            hrdata_r     <= '0;
        end else begin
            unique case (state)
                // ERR2 already shows HREADYOUT=1, so it may take the next
                // address phase exactly like IDLE does.
                ST_IDLE, ST_ERR2: begin
                    if (accept) begin
                        state        <= ST_DPHASE;
                        paddr_r      <= HADDR[ADDR_WIDTH-1:0];
                        pwrite_r     <= HWRITE;
                        hreadyout_r  <= 1'b0;
                        xfer_start_r <= 1'b1;
                    end else begin
                        state        <= ST_IDLE;
                        hreadyout_r  <= 1'b1;
                    end
                end

                // AHB data phase: HWDATA is valid now, so capture it and
                // open the APB setup phase.
                ST_DPHASE: begin
                    state        <= ST_APB;
                    xfer_start_r <= 1'b0;
                    psel_r       <= 1'b1;
                    if (pwrite_r) begin
                        pwdata_r <= HWDATA;
                    end
                end

                // Wait for the APB slave; PREADY low holds here forever.
                ST_APB: begin
                    if (apb_done) begin
                        psel_r <= 1'b0;
                        if (!pwrite_r) begin
                            hrdata_r <= PRDATA;
                        end
                        if (slv_err) begin
                            state       <= ST_ERR1;
                        end else begin
                            state       <= ST_IDLE;
                            hreadyout_r <= 1'b1;
                        end
                    end
                end

                // First ERROR cycle keeps the bus stalled.
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hreadyout_r <= 1'b1;
                end

                default: begin
                    state        <= ST_IDLE;
                    hreadyout_r  <= 1'b1;
                    xfer_start_r <= 1'b0;
                    psel_r       <= 1'b0;
                end
            endcase
        end
    end

    assign HREADYOUT  = hreadyout_r;
    assign xfer_start = xfer_start_r;
    assign PSEL       = psel_r;
    assign PADDR      = paddr_r;
    assign PWRITE     = pwrite_r;
    assign PWDATA     = pwdata_r;
    assign HRDATA     = hrdata_r;

`ifdef APB3_SLVERR_EN
    assign HRESP = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
    assign HRESP = HRESP_OKAY;
`endif

endmodule

// File: tb/tb_ahb_apb_xfer_ctrl.sv
// Self-checking bench for ahb_apb_xfer_ctrl.
// Contains a PENABLE scheduler / APB slave model with programmable wait
// states, an AHB driver task, and negedge monitors that compare DUT output
// against expectations queued when each transfer is driven.
module tb_ahb_apb_xfer_ctrl;
    import ahb_apb_pkg::*;

    localparam int AW = 32;

    // ---------------- clock / reset ----------------
    logic          HCLK = 1'b0;
    logic          HRESETN = 1'b0;
    always #5 HCLK = ~HCLK;

    logic          HSEL, HWRITE;
    logic [31:0]   HADDR, HWDATA;
    logic [1:0]    HTRANS;
    wire           HREADY;
    logic          HREADYOUT, HRESP;
    logic [31:0]   HRDATA;
    logic          PSEL, PWRITE;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PENABLE, PREADY, PSLVERR;
    logic [31:0]   PRDATA;
    logic          xfer_start;

    // Single-slave bus: HREADY is this slave's own HREADYOUT.
    assign HREADY = HREADYOUT;

    ahb_apb_xfer_ctrl #(.ADDR_WIDTH(AW)) dut (
        .HCLK(HCLK), .HRESETN(HRESETN),
        .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS),
        .HREADY(HREADY), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .PSEL(PSEL), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PENABLE(PENABLE), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
        .xfer_start(xfer_start)
    );

    // ---------------- scheduler + APB slave model ----------------
    logic        penable_q;
    int unsigned wcnt;
    int unsigned slv_waits;
    logic [31:0] slv_rdata;
    logic        slv_err;

    always @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            penable_q <= 1'b0;
            wcnt      <= 0;
        end else if (PSEL && !penable_q) begin
            penable_q <= 1'b1;
            wcnt      <= 0;
        end else if (penable_q && PREADY) begin
            penable_q <= 1'b0;
        end else if (penable_q) begin
            wcnt      <= wcnt + 1;
        end
    end

    assign PENABLE = penable_q;
    assign PREADY  = penable_q && (wcnt >= slv_waits);
    assign PRDATA  = slv_rdata;
    assign PSLVERR = PREADY && slv_err;

    // ---------------- scoreboard ----------------
    logic [40:0] exp_q[$];   // {hresp, ahb wait states, hrdata}
    logic [64:0] apb_q[$];   // {pwrite, paddr, pwdata}
    logic [31:0] m_hrdata;
    logic [31:0] m_pwdata;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hreadyout"}, HREADYOUT, 1'b1);
        check({tag, "_hresp"}, HRESP, 1'b0);
        check({tag, "_hrdata"}, HRDATA, 0);
        check({tag, "_psel"}, PSEL, 1'b0);
        check({tag, "_paddr"}, PADDR, 0);
        check({tag, "_pwrite"}, PWRITE, 1'b0);
        check({tag, "_pwdata"}, PWDATA, 0);
        check({tag, "_xfer_start"}, xfer_start, 1'b0);
    endtask

    // ---------------- monitors ----------------
    int   low_cnt;
    logic last_low_resp;
    logic acc_prev, xs_prev, psel_prev;

    always @(negedge HCLK) begin
        logic [64:0] a;
        logic [40:0] e;
        if (!HRESETN) begin
            low_cnt   = 0;
            acc_prev  = 1'b0;
            xs_prev   = 1'b0;
            psel_prev = 1'b0;
        end else begin
            // xfer_start follows an accepted address phase by one cycle.
            check("xfer_start", xfer_start, acc_prev);
            // APB setup phase: one cycle after xfer_start, with captured fields.
            if (PSEL && !psel_prev) begin
                check("psel_after_start", xs_prev, 1'b1);
                check("setup_penable", PENABLE, 1'b0);
                if (apb_q.size() == 0) begin
                    check("apb_unexpected", 1'b1, 1'b0);
                end else begin
                    a = apb_q.pop_front();
                    check("pwrite", PWRITE, a[64]);
                    check("paddr", PADDR, a[63:32]);
                    check("pwdata", PWDATA, a[31:0]);
                end
            end
            // AHB stall length, read data and response at the end of a stall.
            if (!HREADYOUT) begin
                low_cnt++;
                last_low_resp = HRESP;
            end else if (low_cnt > 0) begin
                if (exp_q.size() == 0) begin
                    check("ahb_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("wait_states", low_cnt, e[39:32]);
                    check("hrdata", HRDATA, e[31:0]);
                    check("hresp", HRESP, e[40]);
                    check("hresp_last_low", last_low_resp, e[40]);
                end
                low_cnt = 0;
            end else begin
                check("idle_hresp", HRESP, HRESP_OKAY);
                check("idle_psel", PSEL, 1'b0);
            end
            acc_prev  = HSEL && HREADYOUT && HTRANS[1];
            xs_prev   = xfer_start;
            psel_prev = PSEL;
        end
    end

    // ---------------- driver tasks ----------------
    // Presents one address phase, returns one cycle after it is accepted
    // (at posedge+1), having driven the data phase and queued expectations.
    task automatic ahb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int waits, input logic [31:0] rdata, input logic err);
        logic       rdy;
        int         n;
        logic       e;
        logic [7:0] w;
        HSEL   = 1'b1;
        HTRANS = HTRANS_NONSEQ;
        HADDR  = addr;
        HWRITE = wr;
        n = 0;
        do begin
            @(negedge HCLK);
            rdy = HREADYOUT;
            @(posedge HCLK);
            n++;
        end while (!rdy && n < 64);
        if (!rdy) check("accept_timeout", 1'b0, 1'b1);
        #1;
        HWDATA    = wdata;
        HSEL      = 1'b0;
        HTRANS    = HTRANS_IDLE;
        slv_waits = waits;
        slv_rdata = rdata;
        slv_err   = err;
`ifdef APB3_SLVERR_EN
        e = err;
`else
        e = 1'b0;
`endif
        if (wr) m_pwdata = wdata;
        else    m_hrdata = rdata;
        w = 8'(3 + waits + (e ? 1 : 0));
        apb_q.push_back({wr, addr, m_pwdata});
        exp_q.push_back({e, w, m_hrdata});
    endtask

    task automatic idle_gap(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        HSEL = 1'b0; HWRITE = 1'b0; HADDR = '0; HWDATA = '0; HTRANS = HTRANS_IDLE;
        slv_waits = 0; slv_rdata = '0; slv_err = 1'b0;
        m_hrdata = '0; m_pwdata = '0;

        // Reset values while reset is held.
        repeat (2) @(negedge HCLK);
        check_reset_vals("por");
        @(posedge HCLK); #1;
        HRESETN = 1'b1;
        idle_gap(2);

        // Zero-wait write.
        ahb_xfer(1'b1, 32'h0000_0040, 32'hA5A5_0001, 0, 32'h0, 1'b0);
        idle_gap(6);
        // Read with two PREADY wait cycles.
        ahb_xfer(1'b0, 32'h0000_0044, 32'h5555_AAAA, 2, 32'h1234_5678, 1'b0);
        idle_gap(8);
        // Back-to-back write then read, no bubble between them.
        ahb_xfer(1'b1, 32'h0000_0048, 32'h1111_2222, 0, 32'h0, 1'b0);
        ahb_xfer(1'b0, 32'h0000_004C, 32'h3333_4444, 1, 32'h0BAD_F00D, 1'b0);
        idle_gap(8);
        // Slave error on a read, then a normal write.
        ahb_xfer(1'b0, 32'h0000_0050, 32'h0, 0, 32'hCAFE_0001, 1'b1);
        idle_gap(8);
        ahb_xfer(1'b1, 32'h0000_0054, 32'h7777_8888, 0, 32'h0, 1'b0);
        idle_gap(8);

        // HTRANS IDLE then BUSY with HSEL high: ignored, zero-wait OKAY.
        HSEL = 1'b1; HWRITE = 1'b1; HADDR = 32'h0000_0060;
        for (int k = 0; k < 6; k++) begin
            HTRANS = (k < 3) ? HTRANS_IDLE : HTRANS_BUSY;
            @(negedge HCLK);
            check("ib_psel", PSEL, 1'b0);
            check("ib_hreadyout", HREADYOUT, 1'b1);
            check("ib_hresp", HRESP, 1'b0);
            @(posedge HCLK); #1;
        end
        HSEL = 1'b0; HTRANS = HTRANS_IDLE;
        idle_gap(3);

        // Randomised mix, including acceptance straight out of ERR2.
        for (int k = 0; k < 10; k++) begin
            ahb_xfer(1'($urandom_range(0, 1)), {20'h0, 10'($urandom_range(0, 1023)), 2'b00},
                     $urandom, $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 3) == 0));
            idle_gap($urandom_range(0, 2));
        end
        idle_gap(12);

        // Asynchronous reset while the APB transfer is in progress.
        ahb_xfer(1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 3, 32'h0, 1'b0);
        n = 0;
        while (!PSEL && n < 20) begin
            @(negedge HCLK);
            n++;
        end
        check("reach_apb", PSEL, 1'b1);
        #2;
        HRESETN = 1'b0;
        #1;
        check_reset_vals("async");
        exp_q.delete();
        apb_q.delete();
        m_hrdata = '0;
        m_pwdata = '0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESETN = 1'b1;
        idle_gap(2);
        ahb_xfer(1'b0, 32'h0000_0070, 32'h0, 1, 32'h600D_0070, 1'b0);

        // Drain outstanding expectations.
        n = 0;
        while ((exp_q.size() != 0 || apb_q.size() != 0) && n < 200) begin
            @(posedge HCLK);
            n++;
        end
        idle_gap(2);
        check("drain_ahb", exp_q.size(), 0);
        check("drain_apb", apb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
